// File: rtl/truth_table_sweep_checker.sv
// truth_table_sweep_checker
// Exhaustive on-board tester for an N-input, 1-output combinational block.
// After start it walks every input pattern 0..2**N-1 in ascending order,
// holds each one for SETTLE cycles, samples resp on the last cycle and
// compares it with the expected bit TRUTH[pattern]. It reports the number
// of mismatches, the first failing pattern and a pass flag for the sweep.
// resp is assumed synchronous to clk; there is no internal synchroniser.

module truth_table_sweep_checker #(
    parameter int                  N      = 3,
    parameter int                  SETTLE = 2,
    parameter logic [(1<<N)-1:0]   TRUTH  = 8'b00110100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop_on_fail,
    input  logic         resp,
    output logic [N-1:0] stim,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail,
    output logic         fail_valid
);

    // Settle counter width: must hold SETTLE-1, and is never narrower than one bit.
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [WW-1:0] WAIT_INIT = WW'(SETTLE - 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
    localparam logic [WW-1:0] WAIT_ZERO = WW'(0);
    localparam logic [N-1:0]  STIM_LAST = {N{1'b1}};
    localparam logic [N-1:0]  STIM_ONE  = N'(1);
    localparam logic [N-1:0]  STIM_ZERO = N'(0);
    // err_count is N+1 bits wide so a full-failure sweep (2**N) never wraps.
    localparam logic [N:0]    ERR_ZERO  = {(N+1){1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [N-1:0]  stim_r, stim_s;
    logic [WW-1:0] wait_r, wait_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          pass_r, pass_s;
    logic [N:0]    err_r, err_s;
    logic [N-1:0]  first_r, first_s;
    logic          fv_r, fv_s;
    logic          sof_r, sof_s;
    logic          mismatch_s;
    logic [N:0]    err_inc_s;

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_s    = state_r;
        stim_s     = stim_r;
        wait_s     = wait_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        pass_s     = pass_r;
        err_s      = err_r;
        first_s    = first_r;
        fv_s       = fv_r;
        sof_s      = sof_r;
        mismatch_s = 1'b0;
        err_inc_s  = err_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    stim_s  = STIM_ZERO;
                    wait_s  = WAIT_INIT;
                    busy_s  = 1'b1;
                    err_s   = ERR_ZERO;
                    fv_s    = 1'b0;
                    first_s = STIM_ZERO;
                    pass_s  = 1'b0;
                    sof_s   = stop_on_fail;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (wait_r != WAIT_ZERO) begin
                    // Pattern still settling through the block under test.
                    wait_s = wait_r - WAIT_ONE;
                end else begin
                    // Sample edge: compare the response with the expected bit.
                    mismatch_s = (resp != TRUTH[stim_r]);
                    err_inc_s  = err_r + {{N{1'b0}}, mismatch_s};
                    err_s      = err_inc_s;

                    if (mismatch_s && !fv_r) begin
                        first_s = stim_r;
                        fv_s    = 1'b1;
                    end else begin
                        first_s = first_r;
                    end

                    if ((stim_r == STIM_LAST) || (mismatch_s && sof_r)) begin
                        // Sweep ends here; stim keeps its final pattern.
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = (err_inc_s == ERR_ZERO);
                        state_s = ST_IDLE;
                    end else begin
                        stim_s  = stim_r + STIM_ONE;
                        wait_s  = WAIT_INIT;
                    end
                end
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and aborts a sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            stim_r  <= STIM_ZERO;
            wait_r  <= WAIT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            err_r   <= ERR_ZERO;
            first_r <= STIM_ZERO;
            fv_r    <= 1'b0;
            sof_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            stim_r  <= stim_s;
            wait_r  <= wait_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            err_r   <= err_s;
            first_r <= first_s;
            fv_r    <= fv_s;
            sof_r   <= sof_s;
        end
    end

    assign stim       = stim_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_count  = err_r;
    assign first_fail = first_r;
    assign fail_valid = fv_r;

endmodule

// File: tb/tb_truth_table_sweep_checker.sv
// Self-checking bench for truth_table_sweep_checker (N=3, SETTLE=2).
// A reference model computes the expected sweep outcome when a sweep is
// launched and queues it; the entry is popped and compared when done pulses.

module tb_truth_table_sweep_checker;

    localparam int N      = 3;
    localparam int SETTLE = 2;

    typedef struct packed {
        logic [3:0] err;
        logic [2:0] first;
        logic       fv;
        logic       pass;
        logic [7:0] busy;
        logic [2:0] last_stim;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop_on_fail;
    logic       resp;
    logic [2:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_fail;
    logic       fail_valid;

    logic [7:0] truth_tb = 8'b00110100;
    logic       stuck;
    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       exp_q[$];

    always #5 clk = ~clk;

    // Model of the block under test: either correct or output stuck at 0.
    assign resp = stuck ? 1'b0 : truth_tb[stim];

    truth_table_sweep_checker #(
        .N      (N),
        .SETTLE (SETTLE),
        .TRUTH  (8'b00110100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop_on_fail (stop_on_fail),
        .resp         (resp),
        .stim         (stim),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .first_fail   (first_fail),
        .fail_valid   (fail_valid)
    );

    function automatic exp_t model(input bit stuck_m, input bit sof_m);
        exp_t e;
        logic r;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            r = stuck_m ? 1'b0 : truth_tb[i];
            e.busy      = e.busy + 8'(SETTLE);
            e.last_stim = 3'(i);
            if (r != truth_tb[i]) begin
                e.err = e.err + 4'd1;
                if (!e.fv) begin
                    e.first = 3'(i);
                    e.fv    = 1'b1;
                end
                if (sof_m) break;
            end
        end
        e.pass = (e.err == 4'd0);
        return e;
    endfunction

    // Observes a running sweep until done; checks stim at every busy cycle.
    task automatic monitor_sweep(input int k0, input bit hold, input bit pulse_mid,
                                 output int busy_cycles, output bit got_done);
        int k;
        k = k0;
        got_done = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!hold && c == 0) start = 1'b0;
            if (pulse_mid && c == 4) start = 1'b1;
            if (pulse_mid && c == 5) start = 1'b0;
            if (busy) begin
                n_checks++;
                if (stim !== 3'(k / SETTLE)) begin
                    n_errors++;
                    $display("FAIL stim_seq: busy cycle %0d stim=%0d expected %0d", k, stim, k / SETTLE);
                end
                k++;
            end else if (done) begin
                got_done = 1'b1;
                break;
            end else begin
                n_checks++;
                n_errors++;
                $display("FAIL sweep_state: busy=0 done=0 after %0d busy cycles, expected busy or done", k);
                break;
            end
        end
        busy_cycles = k;
    endtask

    task automatic test_reset();
        start = 1'b0; stop_on_fail = 1'b0; stuck = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stim, busy, done, pass, err_count, first_fail, fail_valid} !== 14'd0) begin
            n_errors++;
            $display("FAIL reset_async: stim=%0d busy=%b done=%b pass=%b err=%0d first=%0d fv=%b, expected all 0",
                     stim, busy, done, pass, err_count, first_fail, fail_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({stim, busy, done, pass, err_count, first_fail, fail_valid} !== 14'd0) begin
            n_errors++;
            $display("FAIL idle_hold: stim=%0d busy=%b done=%b pass=%b err=%0d first=%0d fv=%b, expected all 0",
                     stim, busy, done, pass, err_count, first_fail, fail_valid);
        end
    endtask

    // Launches one sweep, scores it and checks the one-cycle done pulse.
    task automatic test_sweep(input string name, input bit stuck_i, input bit sof_i, input bit pulse_mid);
        int   bc;
        bit   gd;
        exp_t e, o;
        @(negedge clk);
        stuck = stuck_i; stop_on_fail = sof_i; start = 1'b1;
        exp_q.push_back(model(stuck_i, sof_i));
        monitor_sweep(0, 1'b0, pulse_mid, bc, gd);
        stop_on_fail = ~sof_i;
        n_checks++;
        if (!gd) begin
            n_errors++;
            $display("FAIL %s_done: no done pulse after %0d cycles, expected done", name, bc);
        end
        e = exp_q.pop_front();
        o = '{err: err_count, first: first_fail, fv: fail_valid, pass: pass, busy: 8'(bc), last_stim: stim};
        n_checks++;
        if (o !== e) begin
            n_errors++;
            $display("FAIL %s_result: err=%0d first=%0d fv=%b pass=%b busy=%0d stim=%0d, expected err=%0d first=%0d fv=%b pass=%b busy=%0d stim=%0d",
                     name, o.err, o.first, o.fv, o.pass, o.busy, o.last_stim,
                     e.err, e.first, e.fv, e.pass, e.busy, e.last_stim);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== e.pass || stim !== e.last_stim) begin
            n_errors++;
            $display("FAIL %s_after: done=%b busy=%b pass=%b stim=%0d, expected done=0 busy=0 pass=%b stim=%0d",
                     name, done, busy, pass, stim, e.pass, e.last_stim);
        end
    endtask

    task automatic test_back_to_back();
        int   bc;
        bit   gd;
        exp_t e, o;
        @(negedge clk);
        stuck = 1'b1; stop_on_fail = 1'b0; start = 1'b1;
        exp_q.push_back(model(1'b1, 1'b0));
        monitor_sweep(0, 1'b1, 1'b0, bc, gd);
        e = exp_q.pop_front();
        o = '{err: err_count, first: first_fail, fv: fail_valid, pass: pass, busy: 8'(bc), last_stim: stim};
        n_checks++;
        if (!gd || o !== e) begin
            n_errors++;
            $display("FAIL b2b_first: done=%b err=%0d first=%0d fv=%b pass=%b busy=%0d, expected done=1 err=%0d first=%0d fv=%b pass=%b busy=%0d",
                     gd, o.err, o.first, o.fv, o.pass, o.busy, e.err, e.first, e.fv, e.pass, e.busy);
        end
        // start is still high on the done cycle: the next sweep begins here.
        stuck = 1'b0;
        exp_q.push_back(model(1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, pass, err_count, first_fail, fail_valid, stim} !== {1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 3'd0}) begin
            n_errors++;
            $display("FAIL b2b_restart: busy=%b pass=%b err=%0d first=%0d fv=%b stim=%0d, expected busy=1 pass=0 err=0 first=0 fv=0 stim=0",
                     busy, pass, err_count, first_fail, fail_valid, stim);
        end
        monitor_sweep(1, 1'b0, 1'b0, bc, gd);
        e = exp_q.pop_front();
        o = '{err: err_count, first: first_fail, fv: fail_valid, pass: pass, busy: 8'(bc), last_stim: stim};
        n_checks++;
        if (!gd || o !== e) begin
            n_errors++;
            $display("FAIL b2b_second: done=%b err=%0d fv=%b pass=%b busy=%0d, expected done=1 err=%0d fv=%b pass=%b busy=%0d",
                     gd, o.err, o.fv, o.pass, o.busy, e.err, e.fv, e.pass, e.busy);
        end
    endtask

    task automatic test_reset_abort();
        bit reached;
        bit saw_done;
        reached = 1'b0;
        saw_done = 1'b0;
        @(negedge clk);
        stuck = 1'b0; stop_on_fail = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy && stim == 3'd4) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!reached) begin
            n_errors++;
            $display("FAIL abort_reach: stim=%0d busy=%b, expected stim=4 busy=1", stim, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stim, busy, done, pass, err_count, first_fail, fail_valid} !== 14'd0) begin
            n_errors++;
            $display("FAIL abort_reset: stim=%0d busy=%b done=%b pass=%b err=%0d, expected all 0",
                     stim, busy, done, pass, err_count);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_errors++;
            $display("FAIL abort_quiet: done or busy seen after reset abort=1, expected 0");
        end
        test_sweep("after_abort", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sweep("correct", 1'b0, 1'b0, 1'b0);
        test_sweep("stuck_nostop", 1'b1, 1'b0, 1'b0);
        test_sweep("stuck_stop", 1'b1, 1'b1, 1'b0);
        test_sweep("start_ignored", 1'b0, 1'b0, 1'b1);
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
